// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop processes one operand bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, shb_q, res_q, s_q;
  logic             c_q, cout_q;
  logic [CntW-1:0]  cnt_q;
  logic             sum_bit, carry_nxt, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Full-adder cell on the LSBs of the operand shifters.
  always_comb begin
    sum_bit   = sha_q[0] ^ shb_q[0] ^ c_q;
    carry_nxt = (sha_q[0] & shb_q[0]) | (sha_q[0] & c_q) | (shb_q[0] & c_q);
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StRun;
      StRun:   if (last_bit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    BUSY = (state_q == StRun);
    DONE = (state_q == StFin);
    S    = s_q;
    COUT = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    OVF  = ovf_q;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sha_q  <= '0;
      shb_q  <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            sha_q <= A;
            shb_q <= B;
            c_q   <= CIN;
            res_q <= '0;
            cnt_q <= '0;
          end
        end
        StRun: begin
          sha_q <= sha_q >> 1;
          shb_q <= shb_q >> 1;
          c_q   <= carry_nxt;
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          // Results are published only once the final bit is known.
          if (last_bit) begin
            s_q    <= {sum_bit, res_q[WIDTH-1:1]};
            cout_q <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= c_q ^ carry_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver predicts accepted operations from timing rules,
// monitor checks BUSY/DONE timing and results on every falling edge.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .COUT  (COUT)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           edge_idx = 0;
  int           act_k = -1000;
  int           next_ok = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;
  logic         hold_o = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_idx - 1);
    end
  endtask

  // Reference: plain unsigned addition; signed overflow from carries into and out of MSB.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input int k);
    exp_t         m;
    logic [W:0]   full;
    logic [W-1:0] low;
    full        = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    low         = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(ci);
    m.s         = full[W-1:0];
    m.cout      = full[W];
    m.ovf       = low[W-1] ^ full[W];
    m.done_edge = k + W;
    return m;
  endfunction

  task automatic step(input logic rst_n, input logic st, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ci);
    int cur;
    @(negedge CLK);
    RST_N = rst_n;
    START = st;
    A     = a;
    B     = b;
    CIN   = ci;
    @(posedge CLK);
    cur = edge_idx;
    if (!rst_n) begin
      q.delete();
      act_k   = -1000;
      hold_s  = '0;
      hold_c  = 1'b0;
      hold_o  = 1'b0;
      next_ok = cur + 1;
    end else if (st && cur >= next_ok) begin
      q.push_back(model(a, b, ci, cur));
      act_k   = cur;
      next_ok = cur + W + 2;
    end
    edge_idx = cur + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom()), W'($urandom()), 1'b0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    step(1'b1, 1'b1, a, b, ci);
    idle(W + 2);
  endtask

  // Monitor / scoreboard
  initial begin : mon
    int   last;
    logic busy_exp, done_exp;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        last     = edge_idx - 1;
        busy_exp = (last >= act_k) && (last < act_k + int'(W));
        done_exp = (last == act_k + int'(W));
        chk("busy", 64'(BUSY), 64'(busy_exp));
        chk("done", 64'(DONE), 64'(done_exp));
        if (DONE === 1'b1) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: got DONE=1 expected no pending result (edge %0d)",
                     last);
          end else begin
            e = q.pop_front();
            chk("done_edge", 64'(last), 64'(e.done_edge));
            chk("sum", 64'(S), 64'(e.s));
            chk("cout", 64'(COUT), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 64'(OVF), 64'(e.ovf));
            hold_o = e.ovf;
`endif
            hold_s = e.s;
            hold_c = e.cout;
          end
        end else begin
          chk("s_hold", 64'(S), 64'(hold_s));
          chk("cout_hold", 64'(COUT), 64'(hold_c));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf_hold", 64'(OVF), 64'(hold_o));
`endif
        end
      end
    end
  end

  initial begin : drv
    int gap;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    mon_en = 1'b1;
    idle(2);

    op(8'h5A, 8'h3C, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);
    op(8'h7F, 8'h01, 1'b0);
    op(8'h80, 8'h80, 1'b0);
    op(8'h00, 8'h00, 1'b0);

    // START held high with operands changing every cycle
    for (int i = 0; i < 4 * (W + 2); i++)
      step(1'b1, 1'b1, W'($urandom()), W'($urandom()), 1'($urandom()));
    idle(W + 2);

    // Second START during BUSY must be ignored
    step(1'b1, 1'b1, 8'h10, 8'h20, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
    idle(W + 2);

    // Reset mid-operation, then a fresh operation
    step(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(W + 2);
    op(8'h0F, 8'h01, 1'b0);

    // Random operations with random gaps and stray STARTs while busy
    for (int n = 0; n < 30; n++) begin
      step(1'b1, 1'b1, W'($urandom()), W'($urandom()), 1'($urandom()));
      gap = W + 1 + int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++)
        step(1'b1, 1'($urandom_range(0, 3) == 0), W'($urandom()), W'($urandom()),
             1'($urandom()));
    end

    idle(W + 4);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
